fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL take parameter PC_INIT, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 The block SHALL have port CLK  input  1  the single rising-edge clock.
REQ-003 The block SHALL have port RST  input  1  the reset, asynchronous and active-high.
REQ-004 The block SHALL have port ihit  input  1  I-memory read complete this cycle.
REQ-005 The block SHALL have port imemload  input  32  instruction word, valid when ihit=1.
REQ-006 The block SHALL have port iREN  output  1  I-memory read request.
REQ-007 The block SHALL have port imemaddr  output  32  I-memory address, always equal to the internal PC.
REQ-008 The block SHALL have port stall  input  1  downstream IF/ID latch cannot accept; hold outputs.
REQ-009 The block SHALL have port redirect  input  1  branch/jump/jr resolved taken; flush and reload PC.
REQ-010 The block SHALL have port redirect_pc  input  32  new PC for redirect.
REQ-011 The block SHALL have port if_valid  output  1  outputs carry a real instruction (0 = bubble).
REQ-012 The block SHALL have port if_imemload, if_pc, if_pc4  output  32 each  IF_ID bundle fields (instruction, its PC, PC+4).
REQ-013 The block SHALL have port halt_fetched  output  1  HALT opcode fetched, fetch stopped.

Function
REQ-014 The state machine SHALL have states FETCH, HOLD and HALTED.
REQ-015 iREN SHALL be 1 only in FETCH with redirect=0; 0 in HOLD and HALTED.
REQ-016 In FETCH, ihit=1 and stall=0: register {imemload, pc, pc+4} to the outputs, set if_valid=1, PC<=PC+4, next cycle.
REQ-017 In FETCH, ihit=1 and stall=1: capture {imemload, pc, pc+4} in a one-entry hold buffer, PC<=PC+4, go to HOLD, leave outputs unchanged.
REQ-018 In FETCH, ihit=0 and stall=0: set if_valid<=0 (bubble), keep PC.
REQ-019 Whenever stall=1 and redirect=0: if_valid, if_imemload, if_pc and if_pc4 SHALL hold their values.
REQ-020 In HOLD with stall=0: move the buffer to the outputs with if_valid=1, then go to FETCH.
REQ-021 In HOLD with stall=1: remain in HOLD.
REQ-022 redirect=1 SHALL have top priority in every state, including stall=1 and coincident ihit: PC<=redirect_pc, if_valid<=0, buffer discarded, halt_fetched<=0, go to FETCH.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-024 Latency SHALL be 1 cycle from the ihit edge to if_valid when unstalled; throughput SHALL be 1 instruction per cycle with ihit held high.

Reset
REQ-025 RST=1 SHALL immediately force PC=PC_INIT, state=FETCH, if_valid=0, if_imemload=if_pc=if_pc4=0, buffer empty, halt_fetched=0, regardless of CLK, including mid-HOLD.
REQ-026 The first fetch SHALL be requested in the first cycle after RST deasserts (iREN=1, imemaddr=PC_INIT).

Configuration
REQ-027 With FETCH_HALT_DETECT_EN defined: when an instruction with opcode bits[31:26]=6'h3F is delivered to the outputs (REQ-016 or REQ-020), the block SHALL go to HALTED with halt_fetched=1 and PC held; it leaves HALTED only on redirect or RST.
REQ-028 Without FETCH_HALT_DETECT_EN: HALTED SHALL be unreachable, halt_fetched SHALL be tied 0, and HALT opcodes SHALL be fetched as ordinary instructions.

Verification
REQ-029 Reset, ihit=1 constant, stall=0, PC_INIT=0 -> if_pc = 0, 4, 8 on consecutive cycles with if_valid=1; iREN=1 throughout.
REQ-030 ihit=1 with stall=1 at PC=8, stall held 3 cycles -> outputs frozen, iREN=0, imemaddr=12; one cycle after stall drops, if_pc=8 and if_valid=1.
REQ-031 redirect=1, redirect_pc=32'h40, coincident with stall=1 and ihit=1 -> next cycle if_valid=0, imemaddr=32'h40, state FETCH, buffer empty.
REQ-032 With FETCH_HALT_DETECT_EN, imemload=32'hFFFF_FFFF at PC=16 -> if_pc=16 with if_valid=1, halt_fetched=1, iREN=0 and PC=20 thereafter; a redirect to 32'h0 resumes fetching.
REQ-033 PC=32'hFFFF_FFFC with ihit=1 -> if_pc4=0 and imemaddr=0 next cycle.
REQ-034 RST asserted mid-HOLD, asynchronous to CLK -> if_valid=0 and imemaddr=PC_INIT immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a one-entry hold buffer for stalls.
// Optional HALT-opcode detection is compiled in by defining FETCH_HALT_DETECT_EN.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_imemload,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        halt_fetched,
    output logic [1:0]  o_dbg_state,
    output logic        o_dbg_buf_valid
);

    // Handshake: a word is accepted from memory on an edge where iREN=1 and ihit=1;
    // the IF/ID latch takes the outputs on every edge where stall=0, redirect wins over both.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_ipc;
    logic [31:0] r_ipc4;
    logic        r_buf_valid;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_pc4;
    logic        w_deliver;
    logic        w_bubble;
    logic        w_buf_load;
    logic        w_buf_clr;
    logic [31:0] w_dlv_instr;
    logic [31:0] w_dlv_pc;
    logic [31:0] w_dlv_pc4;
    logic        w_halt_op;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_deliver   = 1'b0;
        w_bubble    = 1'b0;
        w_buf_load  = 1'b0;
        w_buf_clr   = 1'b0;
        w_dlv_instr = imemload;
        w_dlv_pc    = r_pc;
        w_dlv_pc4   = w_pc_plus4;
        if (r_state == HOLD) begin
            w_dlv_instr = r_buf_instr;
            w_dlv_pc    = r_buf_pc;
            w_dlv_pc4   = r_buf_pc4;
        end
        if (redirect) begin
            w_state_nxt = FETCH;
            w_pc_nxt    = redirect_pc;
            w_buf_clr   = 1'b1;
        end else begin
            case (r_state)
                FETCH: begin
                    if (ihit) begin
                        w_pc_nxt = w_pc_plus4;
                        if (stall) begin
                            w_buf_load  = 1'b1;
                            w_state_nxt = HOLD;
                        end else begin
                            w_deliver = 1'b1;
                            if (w_halt_op) begin
                                w_state_nxt = HALTED;
                            end
                        end
                    end else if (!stall) begin
                        w_bubble = 1'b1;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        w_deliver   = 1'b1;
                        w_buf_clr   = 1'b1;
                        w_state_nxt = w_halt_op ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        w_bubble = 1'b1;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc        <= PC_INIT;
            r_valid     <= 1'b0;
            r_instr     <= 32'd0;
            r_ipc       <= 32'd0;
            r_ipc4      <= 32'd0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
            r_buf_pc4   <= 32'd0;
        end else begin
            r_pc <= w_pc_nxt;
            if (redirect || w_bubble) begin
                r_valid <= 1'b0;
            end else if (w_deliver) begin
                r_valid <= 1'b1;
                r_instr <= w_dlv_instr;
                r_ipc   <= w_dlv_pc;
                r_ipc4  <= w_dlv_pc4;
            end
            if (w_buf_load) begin
                r_buf_valid <= 1'b1;
                r_buf_instr <= imemload;
                r_buf_pc    <= r_pc;
                r_buf_pc4   <= w_pc_plus4;
            end else if (w_buf_clr) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    logic r_halt;

    assign w_halt_op = (w_dlv_instr[31:26] == 6'h3F);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_halt <= 1'b0;
        end else if (redirect) begin
            r_halt <= 1'b0;
        end else if (w_deliver && w_halt_op) begin
            r_halt <= 1'b1;
        end
    end

    assign halt_fetched = r_halt;
`else
    assign w_halt_op    = 1'b0;
    assign halt_fetched = 1'b0;
`endif

    assign iREN            = (r_state == FETCH) && !redirect;
    assign imemaddr        = r_pc;
    assign if_valid        = r_valid;
    assign if_imemload     = r_instr;
    assign if_pc           = r_ipc;
    assign if_pc4          = r_ipc4;
    assign o_dbg_state     = r_state;
    assign o_dbg_buf_valid = r_buf_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of the fetch rules.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = 32'd0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        iREN;
    logic [31:0] imemaddr;
    logic        if_valid;
    logic [31:0] if_imemload;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        halt_fetched;
    logic [1:0]  dbg_state;
    logic        dbg_buf_valid;

    fetch_stage #(.PC_INIT(PC_INIT)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .imemaddr(imemaddr), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_imemload(if_imemload), .if_pc(if_pc), .if_pc4(if_pc4),
        .halt_fetched(halt_fetched), .o_dbg_state(dbg_state), .o_dbg_buf_valid(dbg_buf_valid)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    // reference model: pending words waiting for the latch, plus a halted flag
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid, m_halted;
    logic [95:0] m_hq[$];

    task automatic model_reset();
        m_pc = PC_INIT; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
        m_valid = 0; m_halted = 0; m_hq.delete();
    endtask

    task automatic model_deliver(input logic [95:0] rec);
        m_instr = rec[95:64]; m_ipc = rec[63:32]; m_ipc4 = rec[31:0]; m_valid = 1;
        if (HALT_EN && rec[95:90] == 6'h3F) m_halted = 1;
    endtask

    task automatic model_step();
        logic [95:0] rec;
        if (redirect) begin
            m_pc = redirect_pc; m_valid = 0; m_hq.delete(); m_halted = 0;
        end else if (m_hq.size() > 0) begin
            if (!stall) model_deliver(m_hq.pop_front());
        end else if (m_halted) begin
            if (!stall) m_valid = 0;
        end else if (ihit) begin
            rec = {imemload, m_pc, m_pc + 32'd4};
            m_pc = m_pc + 32'd4;
            if (stall) m_hq.push_back(rec);
            else model_deliver(rec);
        end else if (!stall) begin
            m_valid = 0;
        end
    endtask

    function automatic logic exp_iren();
        return !m_halted && (m_hq.size() == 0) && !redirect;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3F) w[31] = 1'b0;
        return w;
    endfunction

    // driver tasks
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ihit = 0; stall = 0; redirect = 0; redirect_pc = 0; imemload = 0;
        RST = 1;
        #2;
        model_reset();
        @(negedge CLK);
        RST = 0;
        #1;
    endtask

    task automatic test_reset();
        ihit = 0; stall = 0; redirect = 0;
        RST = 1;
        #2;
        model_reset();
        n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %0b want 0", if_valid); end
        n_checks++; if (if_imemload !== 32'd0) begin n_fail++; $display("FAIL reset_if_imemload: got %h want 0", if_imemload); end
        n_checks++; if (if_pc !== 32'd0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 0", if_pc); end
        n_checks++; if (if_pc4 !== 32'd0) begin n_fail++; $display("FAIL reset_if_pc4: got %h want 0", if_pc4); end
        n_checks++; if (halt_fetched !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %0b want 0", halt_fetched); end
        n_checks++; if (dbg_state !== 2'd0 || dbg_buf_valid !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %0d/%0b want 0/0", dbg_state, dbg_buf_valid); end
        @(negedge CLK);
        RST = 0;
        #1;
        n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL first_fetch_iren: got %0b want 1", iREN); end
        n_checks++; if (imemaddr !== PC_INIT) begin n_fail++; $display("FAIL first_fetch_addr: got %h want %h", imemaddr, PC_INIT); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        do_reset();
        ihit = 1;
        for (int i = 0; i < 3; i++) exp_q.push_back(PC_INIT + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            imemload = rand_instr();
            #1;
            n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL b2b_iren[%0d]: got %0b want 1", i, iREN); end
            tick();
            w = exp_q.pop_front();
            n_checks++; if (if_pc !== w || if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h/%0b want %h/1", i, if_pc, if_valid, w); end
            n_checks++; if (if_pc4 !== w + 32'd4 || if_imemload !== m_instr) begin n_fail++; $display("FAIL b2b_fields[%0d]: got %h/%h want %h/%h", i, if_pc4, if_imemload, w + 32'd4, m_instr); end
        end
        ihit = 0;
    endtask

    task automatic test_stall();
        logic [31:0] i8;
        do_reset();
        ihit = 1;
        imemload = rand_instr(); tick();
        imemload = rand_instr(); tick();
        n_checks++; if (imemaddr !== 32'd8) begin n_fail++; $display("FAIL stall_pre_addr: got %h want 8", imemaddr); end
        i8 = rand_instr();
        imemload = i8; stall = 1;
        tick();
        for (int c = 0; c < 2; c++) begin
            imemload = $urandom;
            #1;
            n_checks++; if (iREN !== 1'b0 || imemaddr !== 32'd12) begin n_fail++; $display("FAIL stall_iren_addr[%0d]: got %0b/%h want 0/0000000c", c, iREN, imemaddr); end
            n_checks++; if (if_pc !== 32'd4 || if_valid !== 1'b1 || dbg_state !== 2'd1) begin n_fail++; $display("FAIL stall_frozen[%0d]: got pc %h v %0b st %0d want 4/1/1", c, if_pc, if_valid, dbg_state); end
            tick();
        end
        n_checks++; if (if_pc !== 32'd4 || if_imemload !== m_instr) begin n_fail++; $display("FAIL stall_frozen_end: got %h/%h want 4/%h", if_pc, if_imemload, m_instr); end
        stall = 0; imemload = rand_instr();
        tick();
        n_checks++; if (if_pc !== 32'd8 || if_valid !== 1'b1 || if_imemload !== i8) begin n_fail++; $display("FAIL stall_release: got %h/%0b/%h want 8/1/%h", if_pc, if_valid, if_imemload, i8); end
        n_checks++; if (dbg_state !== 2'd0 || iREN !== 1'b1) begin n_fail++; $display("FAIL stall_back_fetch: got st %0d iren %0b want 0/1", dbg_state, iREN); end
        tick();
        n_checks++; if (if_pc !== 32'd12 || if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_next: got %h/%0b want c/1", if_pc, if_valid); end
        ihit = 0;
    endtask

    task automatic test_redirect();
        do_reset();
        ihit = 1; imemload = rand_instr();
        tick();
        stall = 1; redirect = 1; redirect_pc = 32'h40; imemload = rand_instr();
        #1;
        n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL redir_iren: got %0b want 0", iREN); end
        tick();
        redirect = 0; stall = 0; ihit = 0;
        #1;
        n_checks++; if (if_valid !== 1'b0 || imemaddr !== 32'h40) begin n_fail++; $display("FAIL redir_stall: got %0b/%h want 0/40", if_valid, imemaddr); end
        n_checks++; if (dbg_state !== 2'd0 || dbg_buf_valid !== 1'b0) begin n_fail++; $display("FAIL redir_state: got %0d/%0b want 0/0", dbg_state, dbg_buf_valid); end
        ihit = 1; stall = 1; imemload = rand_instr();
        tick();
        n_checks++; if (dbg_state !== 2'd1 || dbg_buf_valid !== 1'b1) begin n_fail++; $display("FAIL redir_hold_enter: got %0d/%0b want 1/1", dbg_state, dbg_buf_valid); end
        redirect = 1; redirect_pc = 32'h80;
        tick();
        redirect = 0;
        n_checks++; if (if_valid !== 1'b0 || imemaddr !== 32'h80 || dbg_state !== 2'd0 || dbg_buf_valid !== 1'b0) begin n_fail++; $display("FAIL redir_from_hold: got %0b/%h/%0d/%0b want 0/80/0/0", if_valid, imemaddr, dbg_state, dbg_buf_valid); end
        stall = 0; imemload = rand_instr();
        tick();
        n_checks++; if (if_pc !== 32'h80 || if_valid !== 1'b1) begin n_fail++; $display("FAIL redir_resume: got %h/%0b want 80/1", if_pc, if_valid); end
        ihit = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect = 1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 0; ihit = 1; imemload = rand_instr();
        tick();
        n_checks++; if (if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'd0) begin n_fail++; $display("FAIL wrap_pc4: got %h/%h want fffffffc/0", if_pc, if_pc4); end
        n_checks++; if (imemaddr !== 32'd0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imemaddr); end
        ihit = 0;
    endtask

    task automatic test_halt();
        do_reset();
        redirect = 1; redirect_pc = 32'd16;
        tick();
        redirect = 0; ihit = 1; imemload = 32'hFFFF_FFFF;
        tick();
        imemload = rand_instr();
        #1;
        n_checks++; if (if_pc !== 32'd16 || if_valid !== 1'b1 || if_imemload !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL halt_delivered: got %h/%0b/%h want 10/1/ffffffff", if_pc, if_valid, if_imemload); end
`ifdef FETCH_HALT_DETECT_EN
        n_checks++; if (halt_fetched !== 1'b1 || iREN !== 1'b0 || imemaddr !== 32'd20) begin n_fail++; $display("FAIL halt_set: got %0b/%0b/%h want 1/0/14", halt_fetched, iREN, imemaddr); end
        tick(); tick();
        n_checks++; if (halt_fetched !== 1'b1 || iREN !== 1'b0 || imemaddr !== 32'd20 || dbg_state !== 2'd2) begin n_fail++; $display("FAIL halt_held: got %0b/%0b/%h/%0d want 1/0/14/2", halt_fetched, iREN, imemaddr, dbg_state); end
        redirect = 1; redirect_pc = 32'd0;
        tick();
        redirect = 0;
        #1;
        n_checks++; if (halt_fetched !== 1'b0 || iREN !== 1'b1 || imemaddr !== 32'd0) begin n_fail++; $display("FAIL halt_redirect: got %0b/%0b/%h want 0/1/0", halt_fetched, iREN, imemaddr); end
        tick();
        n_checks++; if (if_pc !== 32'd0 || if_valid !== 1'b1) begin n_fail++; $display("FAIL halt_resume: got %h/%0b want 0/1", if_pc, if_valid); end
`else
        n_checks++; if (halt_fetched !== 1'b0 || iREN !== 1'b1 || imemaddr !== 32'd20) begin n_fail++; $display("FAIL halt_ordinary: got %0b/%0b/%h want 0/1/14", halt_fetched, iREN, imemaddr); end
        tick();
        n_checks++; if (if_pc !== 32'd20 || if_valid !== 1'b1 || halt_fetched !== 1'b0) begin n_fail++; $display("FAIL halt_continue: got %h/%0b/%0b want 14/1/0", if_pc, if_valid, halt_fetched); end
`endif
        ihit = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        ihit = 1;
        imemload = rand_instr(); tick();
        imemload = rand_instr(); tick();
        stall = 1; imemload = rand_instr();
        tick();
        n_checks++; if (dbg_state !== 2'd1 || imemaddr !== 32'd12) begin n_fail++; $display("FAIL areset_pre_hold: got %0d/%h want 1/c", dbg_state, imemaddr); end
        #2;
        RST = 1;
        #1;
        n_checks++; if (if_valid !== 1'b0 || imemaddr !== PC_INIT) begin n_fail++; $display("FAIL areset_immediate: got %0b/%h want 0/%h", if_valid, imemaddr, PC_INIT); end
        n_checks++; if (dbg_state !== 2'd0 || dbg_buf_valid !== 1'b0 || if_pc !== 32'd0) begin n_fail++; $display("FAIL areset_state: got %0d/%0b/%h want 0/0/0", dbg_state, dbg_buf_valid, if_pc); end
        model_reset();
        ihit = 0; stall = 0;
        @(negedge CLK);
        RST = 0;
        #1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ihit = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 8);
            redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            imemload = ($urandom_range(0, 99) < 5) ? {6'h3F, 26'($urandom)} : rand_instr();
            #1;
            n_checks++; if (iREN !== exp_iren() || imemaddr !== m_pc) begin n_fail++; $display("FAIL rand_req[%0d]: got %0b/%h want %0b/%h", i, iREN, imemaddr, exp_iren(), m_pc); end
            tick();
            n_checks++; if (if_valid !== m_valid || halt_fetched !== m_halted) begin n_fail++; $display("FAIL rand_flags[%0d]: got v%0b h%0b want v%0b h%0b", i, if_valid, halt_fetched, m_valid, m_halted); end
            n_checks++; if (if_imemload !== m_instr || if_pc !== m_ipc || if_pc4 !== m_ipc4) begin n_fail++; $display("FAIL rand_bundle[%0d]: got %h/%h/%h want %h/%h/%h", i, if_imemload, if_pc, if_pc4, m_instr, m_ipc, m_ipc4); end
        end
        ihit = 0; stall = 0; redirect = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_wrap();
        test_halt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
